// File: rtl/pcm_fp_frontend_pkg.sv
// Shared definitions for the PCM-to-double front end and the NLMS adapter it feeds.
package pcm_fp_frontend_pkg;

    localparam logic [63:0] FP64_ZERO = 64'h0;
    localparam int unsigned EXP_BIAS  = 1023;

    // FPU op-codes, common to the adapter datapath
    localparam logic [2:0] FPU_OP_ADD = 3'b000;
    localparam logic [2:0] FPU_OP_SUB = 3'b001;
    localparam logic [2:0] FPU_OP_MUL = 3'b010;
    localparam logic [2:0] FPU_OP_DIV = 3'b011;

    typedef enum logic [2:0] {
        StIdle,
        StCvtFar,
        StCvtNear,
        StPush,
        StIssue,
        StWait
    } state_t;

endpackage

// File: rtl/pcm_fp_frontend_cvt.sv
// Exact signed PCM_W-bit integer to IEEE-754 double conversion (combinational).
module int_to_fp64
    import pcm_fp_frontend_pkg::*;
#(
    parameter int unsigned PCM_W = 16
) (
    input  logic [PCM_W-1:0] value,
    output logic [63:0]      result
);

    logic [PCM_W:0]  mag;
    logic [51:0]     mantissa;
    logic [10:0]     exponent;
    int unsigned     lead;

    // Magnitude at PCM_W+1 bits so the most negative input has a representable |x|
    always_comb begin
        mag  = value[PCM_W-1] ? (~{value[PCM_W-1], value} + 1'b1) : {1'b0, value};
        lead = 0;
        for (int unsigned i = 0; i <= PCM_W; i++) begin
            if (mag[i]) lead = i;
        end
        // Left-justify so the leading one lands on bit 52 and falls off the mantissa
        mantissa = 52'(64'(mag) << (52 - lead));
        exponent = 11'(EXP_BIAS + lead);
        if (value == '0) result = FP64_ZERO;
        else             result = {value[PCM_W-1], exponent, mantissa};
    end

endmodule

// File: rtl/pcm_fp_frontend.sv
// Front end for the NLMS echo adapter: converts PCM pairs to doubles, delays the
// near-end stream, and sequences enable_sampling / enable against adapt_ready.
module pcm_fp_frontend
    import pcm_fp_frontend_pkg::*;
#(
    parameter int unsigned PCM_W     = 16,
    parameter int unsigned LAG_DEPTH = 2,
    parameter int unsigned PRIME_N   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcm_valid,
    input  logic [PCM_W-1:0] pcm_far,
    input  logic [PCM_W-1:0] pcm_near,
    input  logic             adapt_ready,
    output logic [63:0]      signal,
    output logic [63:0]      signal_lag,
    output logic             enable_sampling,
    output logic             enable,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       drop_cnt
);

    state_t           state_q;
    logic             skid_valid_q;
    logic [PCM_W-1:0] skid_far_q, skid_near_q;
    logic [PCM_W-1:0] cur_far_q, cur_near_q;
    logic [63:0]      far_q;
    logic [63:0]      dl_q    [LAG_DEPTH+1];
    logic [63:0]      dl_next [LAG_DEPTH+1];
    logic [7:0]       prime_cnt_q;
    logic             ready_q;

    logic             idle, take_skid, take_new, load_skid, drop, ready_rise;
    logic [PCM_W-1:0] cvt_in;
    logic [63:0]      cvt_out;

    // Pending-pair arbitration: the buffered pair always wins over a fresh one
    always_comb begin
        idle       = (state_q == StIdle);
        take_skid  = idle & skid_valid_q;
        take_new   = idle & ~skid_valid_q & pcm_valid;
        load_skid  = ~idle & ~skid_valid_q & pcm_valid;
        drop       = pcm_valid & skid_valid_q;
        ready_rise = adapt_ready & ~ready_q;
        cvt_in     = (state_q == StCvtNear) ? cur_near_q : cur_far_q;
    end

    // Single converter shared between the far and near samples
    int_to_fp64 #(
        .PCM_W (PCM_W)
    ) u_cvt (
        .value  (cvt_in),
        .result (cvt_out)
    );

    // Delay line as it will look after this sample is shifted in; tap 0 is the current sample
    always_comb begin
        dl_next[0] = cvt_out;
        for (int unsigned i = 1; i <= LAG_DEPTH; i++) begin
            dl_next[i] = dl_q[i-1];
        end
    end

    // Skid buffer, drop accounting and adapt_ready edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_far_q   <= '0;
            skid_near_q  <= '0;
            overrun      <= 1'b0;
            drop_cnt     <= '0;
            ready_q      <= 1'b0;
        end else begin
            ready_q <= adapt_ready;
            if (take_skid) begin
                skid_valid_q <= 1'b0;
            end else if (load_skid) begin
                skid_valid_q <= 1'b1;
                skid_far_q   <= pcm_far;
                skid_near_q  <= pcm_near;
            end
            if (drop) begin
                overrun <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Sequencer; outputs are loaded on the edge into PUSH/ISSUE so they are visible in that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            cur_far_q       <= '0;
            cur_near_q      <= '0;
            far_q           <= FP64_ZERO;
            dl_q            <= '{default: FP64_ZERO};
            prime_cnt_q     <= '0;
            signal          <= FP64_ZERO;
            signal_lag      <= FP64_ZERO;
            enable_sampling <= 1'b0;
            enable          <= 1'b0;
            busy            <= 1'b0;
        end else begin
            enable_sampling <= 1'b0;
            enable          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (take_skid) begin
                        cur_far_q  <= skid_far_q;
                        cur_near_q <= skid_near_q;
                        state_q    <= StCvtFar;
                    end else if (take_new) begin
                        cur_far_q  <= pcm_far;
                        cur_near_q <= pcm_near;
                        state_q    <= StCvtFar;
                    end
                end
                StCvtFar: begin
                    far_q   <= cvt_out;
                    state_q <= StCvtNear;
                end
                StCvtNear: begin
                    dl_q            <= dl_next;
                    signal          <= far_q;
                    signal_lag      <= dl_next[LAG_DEPTH];
                    enable_sampling <= 1'b1;
                    if (prime_cnt_q < 8'(PRIME_N)) prime_cnt_q <= prime_cnt_q + 8'd1;
                    state_q <= StPush;
                end
                StPush: begin
                    if (prime_cnt_q < 8'(PRIME_N)) begin
                        state_q <= StIdle;
                    end else begin
                        enable  <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // Only a fresh 0->1 transition ends the wait, never a stale high level
                    if (ready_rise) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_fp_frontend.sv
// Scoreboard bench for pcm_fp_frontend; reference uses real-number conversion and a sample history.
module tb_pcm_fp_frontend;

    localparam int PCM_W = 16;
    localparam int LAG   = 2;
    localparam int PRIME = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pcm_valid = 1'b0;
    logic [PCM_W-1:0] pcm_far = '0;
    logic [PCM_W-1:0] pcm_near = '0;
    logic             adapt_ready = 1'b0;
    logic [63:0]      signal, signal_lag;
    logic             enable_sampling, enable, busy, overrun;
    logic [7:0]       drop_cnt;

    pcm_fp_frontend #(
        .PCM_W     (PCM_W),
        .LAG_DEPTH (LAG),
        .PRIME_N   (PRIME)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pcm_valid       (pcm_valid),
        .pcm_far         (pcm_far),
        .pcm_near        (pcm_near),
        .adapt_ready     (adapt_ready),
        .signal          (signal),
        .signal_lag      (signal_lag),
        .enable_sampling (enable_sampling),
        .enable          (enable),
        .busy            (busy),
        .overrun         (overrun),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [63:0] q_sig[$];
    logic [63:0] q_lag[$];
    bit          q_en[$];
    logic [63:0] hist[$];
    int          n_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] to_fp(input logic [PCM_W-1:0] x);
        int v;
        v = int'($signed(x));
        return $realtobits($itor(v));
    endfunction

    // Reference: record an accepted pair and its expected adapter-facing response
    task automatic model_pair(input logic [PCM_W-1:0] f, input logic [PCM_W-1:0] n,
                              output bit exp_en);
        hist.push_back(to_fp(n));
        n_acc++;
        q_sig.push_back(to_fp(f));
        q_lag.push_back(hist.size() > LAG ? hist[hist.size()-1-LAG] : 64'h0);
        exp_en = (n_acc >= PRIME);
        q_en.push_back(exp_en);
    endtask

    task automatic pulse(input logic [PCM_W-1:0] f, input logic [PCM_W-1:0] n);
        @(posedge clk); #1;
        pcm_valid = 1'b1; pcm_far = f; pcm_near = n;
        @(posedge clk); #1;
        pcm_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Adapter finishing an update: ready falls, then rises after d cycles
    task automatic handshake(input int d);
        adapt_ready = 1'b0;
        wait_cycles(d);
        adapt_ready = 1'b1;
        wait_cycles(2);
        @(negedge clk);
        chk("busy_clear", {63'd0, busy}, 64'd0);
    endtask

    task automatic send_normal(input logic [PCM_W-1:0] f, input logic [PCM_W-1:0] n,
                               input int gap);
        bit e;
        model_pair(f, n, e);
        pulse(f, n);
        wait_cycles(6);
        if (e) handshake(1 + int'($urandom_range(4)));
        wait_cycles(gap);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample
    bit en_due = 1'b0;
    bit en_exp = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_due = 1'b0;
        end else begin
            if (en_due) begin
                chk("enable_after_push", {63'd0, enable}, {63'd0, en_exp});
                if (en_exp) chk("busy_after_enable", {63'd0, busy}, 64'd1);
                en_due = 1'b0;
            end else if (enable) begin
                chk("unexpected_enable", {63'd0, enable}, 64'd0);
            end
            if (enable_sampling) begin
                if (q_sig.size() == 0) begin
                    chk("unexpected_enable_sampling", {63'd0, enable_sampling}, 64'd0);
                end else begin
                    chk("signal", signal, q_sig.pop_front());
                    chk("signal_lag", signal_lag, q_lag.pop_front());
                    en_exp = q_en.pop_front();
                    en_due = 1'b1;
                end
            end
        end
    end

    logic [PCM_W-1:0] dir_far [5];
    bit               e_tmp;

    initial begin
        dir_far[0] = 16'h0001; dir_far[1] = 16'hFFFF; dir_far[2] = 16'h8000;
        dir_far[3] = 16'h7FFF; dir_far[4] = 16'h0000;

        // Reset state
        wait_cycles(3);
        @(negedge clk);
        chk("rst_signal", signal, 64'h0);
        chk("rst_signal_lag", signal_lag, 64'h0);
        chk("rst_flags", {59'd0, enable_sampling, enable, busy, overrun}, 64'd0);
        chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(2);

        // Directed conversions with near = 1..5; priming and lag alignment
        for (int i = 0; i < 5; i++) send_normal(dir_far[i], PCM_W'(i + 1), 12);

        // Stale ready: level high across ISSUE must not end WAIT
        adapt_ready = 1'b1;
        model_pair(16'h1234, 16'hF00D, e_tmp);
        pulse(16'h1234, 16'hF00D);
        wait_cycles(14);
        @(negedge clk);
        chk("stale_ready_hold", {63'd0, busy}, 64'd1);
        handshake(2);

        // Backpressure: one buffered, rest dropped
        adapt_ready = 1'b0;
        model_pair(16'h0100, 16'h0200, e_tmp);
        pulse(16'h0100, 16'h0200);
        wait_cycles(6);
        model_pair(16'hABCD, 16'h4321, e_tmp);
        pulse(16'hABCD, 16'h4321);
        pulse(16'h1111, 16'h2222);
        pulse(16'h3333, 16'h4444);
        @(negedge clk);
        chk("bp_overrun", {63'd0, overrun}, 64'd1);
        chk("bp_drop_cnt", {56'd0, drop_cnt}, 64'd2);
        chk("bp_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 260; i++) pulse(PCM_W'($urandom), PCM_W'($urandom));
        @(negedge clk);
        chk("drop_cnt_saturate", {56'd0, drop_cnt}, 64'd255);
        #1;
        adapt_ready = 1'b1;
        wait_cycles(10);
        handshake(1);

        // Reset during WAIT
        adapt_ready = 1'b0;
        model_pair(16'h0042, 16'h0024, e_tmp);
        pulse(16'h0042, 16'h0024);
        wait_cycles(6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_es", {63'd0, enable_sampling}, 64'd0);
        chk("arst_overrun", {63'd0, overrun}, 64'd0);
        chk("arst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
        chk("arst_signal", signal, 64'h0);
        hist.delete();
        n_acc = 0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 4; i++) send_normal(PCM_W'($urandom), PCM_W'($urandom), 3);

        // Random traffic
        for (int i = 0; i < 16; i++)
            send_normal(PCM_W'($urandom), PCM_W'($urandom), 1 + int'($urandom_range(5)));

        wait_cycles(10);
        chk("scoreboard_drained", 64'(q_sig.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
